// File: rtl/regfile_dump_ctrl_if.sv
// Bundle between the dump sequencer, the debug unit and the register file's
// debug read port. The sequencer takes the master side.
interface regfile_dump_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              done;
  logic              busy;
  logic              rf_debug_on;
  logic [ADDR_W-1:0] rf_debug_addr;
  logic [DATA_W-1:0] rf_debug_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  start, rf_debug_data, tx_ready,
    output done, busy, rf_debug_on, rf_debug_addr, tx_data, tx_valid
  );

  modport slave (
    output start, rf_debug_data, tx_ready,
    input  done, busy, rf_debug_on, rf_debug_addr, tx_data, tx_valid
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Register file dump sequencer: walks the debug read port over all registers
// and streams each word to the transmitter as four bytes, LSB first.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; all outputs low
//   S_SETUP | debug address presented; word captured at the closing edge
//   S_SEND  | one byte of the held word offered on tx_data/tx_valid
//   S_DONE  | single-cycle done pulse, then back to idle
module regfile_dump_ctrl #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  regfile_dump_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [1:0]        idx_q, idx_d;

  logic       on_o, busy_o, done_o, valid_o;
  logic [7:0] byte_sel;
  logic [7:0] data_o;

  // State and datapath registers; reset abandons any partially sent word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

  // Byte lane of the held word selected by the byte index.
  always_comb begin
    byte_sel = hold_q[7:0];
    case (idx_q)
      2'd0: byte_sel = hold_q[7:0];
      2'd1: byte_sel = hold_q[15:8];
      2'd2: byte_sel = hold_q[23:16];
      2'd3: byte_sel = hold_q[31:24];
      default: byte_sel = hold_q[7:0];
    endcase
  end

  // Next-state and output decode. The hold register only loads in SETUP, so
  // read-port changes while bytes are going out never leak into the stream.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    on_o    = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    valid_o = 1'b0;
    data_o  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SETUP;
          addr_d  = '0;
          idx_d   = '0;
        end
      end
      S_SETUP: begin
        on_o    = 1'b1;
        busy_o  = 1'b1;
        hold_d  = bus.rf_debug_data;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        on_o    = 1'b1;
        busy_o  = 1'b1;
        valid_o = 1'b1;
        data_o  = byte_sel;
        if (bus.tx_ready) begin
          if (idx_q == 2'd3) begin
            idx_d = '0;
            if (addr_q == LAST_ADDR) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_SETUP;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        on_o    = 1'b1;
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
        addr_d  = '0;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.rf_debug_on   = on_o;
  assign bus.rf_debug_addr = addr_q;
  assign bus.busy          = busy_o;
  assign bus.done          = done_o;
  assign bus.tx_valid      = valid_o;
  assign bus.tx_data       = data_o;

endmodule
